axis_output_pipe: RTL and testbench

// - Output stage directly downstream of the maxpool engine: takes its wide beat (S_WORDS words plus per-word

---
 rtl/axis_output_pipe.sv | 175 +++++++++++++++++
 tb/tb_axis_output_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_output_pipe.sv
// axis_output_pipe
// Output stage behind the maxpool engine.
// - Takes one wide beat of S_WORDS words, each with its own keep bit.
// - Drops the unkept words and packs the rest in order into a buffer.
// - Re-emits the packed words as a narrow M_WORDS-wide AXI-Stream for the DMA.
// - s_axis_tlast flushes whatever is left in the buffer and marks the final output beat.
// - A tlast beat with no kept words still produces one empty beat (tkeep=0, tlast=1),
//   so the DMA transfer terminates.
// Optional feature: define OUTPUT_PIPE_STATS_EN to add the m_beat_count port and its
// per-packet output-beat counter. Without it the datapath is identical and no counter
// exists.
module axis_output_pipe #(
    parameter int WORD_WIDTH = 8,
    parameter int S_WORDS    = 40,
    parameter int M_WORDS    = 8
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [S_WORDS*WORD_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_WORDS-1:0]              s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [M_WORDS*WORD_WIDTH-1:0]   m_axis_tdata,
    output logic [M_WORDS*WORD_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast
`ifdef OUTPUT_PIPE_STATS_EN
    ,
    output logic [31:0]                     m_beat_count
`endif
);

    // Buffer depth is fixed by the push/pop exclusivity: a push happens only with
    // fewer than M_WORDS words held, so at most M_WORDS-1 + S_WORDS words are ever held.
    localparam int BUF_WORDS = S_WORDS + M_WORDS - 1;
    localparam int CNT_W     = $clog2(BUF_WORDS + 1);
    localparam int KPW       = WORD_WIDTH / 8;

    logic [WORD_WIDTH-1:0]          buf_reg [BUF_WORDS];
    logic [WORD_WIDTH-1:0]          buf_next [BUF_WORDS];
    logic [CNT_W-1:0]               count_reg;
    logic [CNT_W-1:0]               count_next;
    logic                           flush_reg;
    logic                           flush_next;

    logic                           m_tvalid_reg;
    logic [M_WORDS*WORD_WIDTH-1:0]  m_tdata_reg;
    logic [M_WORDS*KPW-1:0]         m_tkeep_reg;
    logic                           m_tlast_reg;

    logic                           out_free;
    logic                           pop;
    logic                           accept;
    logic [CNT_W-1:0]               take_n;
    logic [CNT_W-1:0]               pos [S_WORDS+1];
    logic [M_WORDS*WORD_WIDTH-1:0]  pop_data;
    logic [M_WORDS*KPW-1:0]         pop_keep;
    logic                           pop_last;

    // Ready depends on registered state only, never on m_axis_tready.
    assign s_axis_tready = (count_reg < CNT_W'(M_WORDS)) && !flush_reg;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign out_free      = !m_tvalid_reg || m_axis_tready;

    // A flush with count==0 still pops; that pop is the empty tlast beat.
    assign pop           = out_free && ((count_reg >= CNT_W'(M_WORDS)) || flush_reg);
    assign take_n        = (count_reg >= CNT_W'(M_WORDS)) ? CNT_W'(M_WORDS) : count_reg;
    assign pop_last      = flush_reg && (count_reg == take_n);

    assign m_axis_tvalid = m_tvalid_reg;
    assign m_axis_tdata  = m_tdata_reg;
    assign m_axis_tkeep  = m_tkeep_reg;
    assign m_axis_tlast  = m_tlast_reg;

    // Exclusive prefix sum of keep: destination offset of each kept input word.
    always_comb begin
        pos[0] = '0;
        for (int i = 0; i < S_WORDS; i++) begin
            pos[i+1] = pos[i] + CNT_W'(s_axis_tkeep[i]);
        end
    end

    // The oldest take_n words form the outgoing beat; the unused upper lanes are zeroed.
    genvar gi;
    generate
        for (gi = 0; gi < M_WORDS; gi++) begin : g_lane
            assign pop_data[gi*WORD_WIDTH +: WORD_WIDTH] =
                (CNT_W'(gi) < take_n) ? buf_reg[gi] : '0;
            assign pop_keep[gi*KPW +: KPW] =
                (CNT_W'(gi) < take_n) ? {KPW{1'b1}} : '0;
        end
    endgenerate

    // Buffer update: a pop shifts down by take_n; an accept appends compacted words at count.
    always_comb begin
        buf_next   = buf_reg;
        count_next = count_reg;
        flush_next = flush_reg;
        if (pop) begin
            for (int j = 0; j < BUF_WORDS; j++) begin
                buf_next[j] = '0;
                for (int s = j; (s < BUF_WORDS) && (s <= j + M_WORDS); s++) begin
                    if (take_n == CNT_W'(s - j)) begin
                        buf_next[j] = buf_reg[s];
                    end
                end
            end
            count_next = count_reg - take_n;
            if (count_reg == take_n) begin
                flush_next = 1'b0;
            end
        end else if (accept) begin
            for (int j = 0; j < BUF_WORDS; j++) begin
                for (int i = 0; i < S_WORDS; i++) begin
                    if (s_axis_tkeep[i] && ((count_reg + pos[i]) == CNT_W'(j))) begin
                        buf_next[j] = s_axis_tdata[i*WORD_WIDTH +: WORD_WIDTH];
                    end
                end
            end
            count_next = count_reg + pos[S_WORDS];
            flush_next = s_axis_tlast;
        end
    end

    // Buffer storage needs no reset: count_reg alone defines which words are valid.
    always_ff @(posedge aclk) begin
        buf_reg <= buf_next;
    end

    // Occupancy and the flush flag; reset discards any partial packet.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            count_reg <= '0;
            flush_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            flush_reg <= flush_next;
        end
    end

    // Output register: loads only when free, so a stalled beat holds its data, keep and last.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_tvalid_reg <= 1'b0;
            m_tdata_reg  <= '0;
            m_tkeep_reg  <= '0;
            m_tlast_reg  <= 1'b0;
        end else if (out_free) begin
            m_tvalid_reg <= pop;
            if (pop) begin
                m_tdata_reg <= pop_data;
                m_tkeep_reg <= pop_keep;
                m_tlast_reg <= pop_last;
            end
        end
    end

`ifdef OUTPUT_PIPE_STATS_EN
    // Per-packet count of accepted output beats; saturates and restarts after tlast.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_beat_count <= '0;
        end else if (m_tvalid_reg && m_axis_tready) begin
            if (m_tlast_reg) begin
                m_beat_count <= '0;
            end else if (m_beat_count != 32'hFFFF_FFFF) begin
                m_beat_count <= m_beat_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_output_pipe.sv
// tb_axis_output_pipe
// Directed table of packets with hand-computed output beats, plus a hand-written
// reset-mid-drain sequence. Define OUTPUT_PIPE_STATS_EN to also check m_beat_count.
module tb_axis_output_pipe;

    localparam int WW = 8;
    localparam int SW = 40;
    localparam int MW = 8;

    logic               aclk = 1'b0;
    logic               areset = 1'b1;
    logic               s_axis_tvalid = 1'b0;
    logic               s_axis_tready;
    logic [SW*WW-1:0]   s_axis_tdata = '0;
    logic [SW-1:0]      s_axis_tkeep = '0;
    logic               s_axis_tlast = 1'b0;
    logic               m_axis_tvalid;
    logic               m_axis_tready = 1'b1;
    logic [MW*WW-1:0]   m_axis_tdata;
    logic [MW*WW/8-1:0] m_axis_tkeep;
    logic               m_axis_tlast;
`ifdef OUTPUT_PIPE_STATS_EN
    logic [31:0]        m_beat_count;
`endif

    axis_output_pipe #(.WORD_WIDTH(WW), .S_WORDS(SW), .M_WORDS(MW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
`ifdef OUTPUT_PIPE_STATS_EN
        .m_beat_count  (m_beat_count),
`endif
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [SW*WW-1:0] data;
        logic [SW-1:0]    keep;
        logic             last;
    } in_vec_t;

    typedef struct {
        logic [MW*WW-1:0] data;
        logic [MW-1:0]    keep;
        logic             last;
    } beat_t;

    typedef struct {
        string   name;
        logic    bp;
        int      n_in;
        in_vec_t ins [2];
        int      n_exp;
        beat_t   exp [5];
    } case_t;

    int    checks = 0;
    int    passes = 0;
    beat_t got_q [$];
    beat_t exp_q [$];
    logic  bp_mode = 1'b0;
    int    bp_idx = 0;
    case_t cases [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [SW*WW-1:0] ramp(input int base);
        logic [SW*WW-1:0] r;
        for (int i = 0; i < SW; i++) begin
            r[i*WW +: WW] = WW'(base + i);
        end
        return r;
    endfunction

    function automatic beat_t mk_beat(input int first, input int step, input int n, input logic last);
        beat_t b;
        b.data = '0;
        b.keep = '0;
        for (int l = 0; l < n; l++) begin
            b.data[l*WW +: WW] = WW'(first + step * l);
            b.keep[l] = 1'b1;
        end
        b.last = last;
        return b;
    endfunction

    // Downstream ready: constant 1, or the repeating 1,0,0,1 stall pattern.
    always @(posedge aclk) begin
        #1;
        if (bp_mode) begin
            m_axis_tready = ((bp_idx % 4) == 0) || ((bp_idx % 4) == 3);
            bp_idx++;
        end else begin
            m_axis_tready = 1'b1;
        end
    end

    // Output monitor: records each handshake and checks that stalled beats hold steady.
    beat_t held;
    logic  stall_prev = 1'b0;
    int    pkt_beat = 0;
    always @(negedge aclk) begin
        beat_t cur;
        cur.data = m_axis_tdata;
        cur.keep = m_axis_tkeep;
        cur.last = m_axis_tlast;
        if (areset) begin
            stall_prev = 1'b0;
            pkt_beat   = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 64'(m_axis_tvalid), 64'(1'b1));
                check("stall_data",  64'(cur.data), 64'(held.data));
                check("stall_keep",  64'(cur.keep), 64'(held.keep));
                check("stall_last",  64'(cur.last), 64'(held.last));
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held = cur;
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back(cur);
`ifdef OUTPUT_PIPE_STATS_EN
                check("beat_count", 64'(m_beat_count), 64'(pkt_beat));
`endif
                pkt_beat = cur.last ? 0 : pkt_beat + 1;
            end
        end
    end

    task automatic send(input in_vec_t v);
        int t;
        @(negedge aclk);
        s_axis_tdata  = v.data;
        s_axis_tkeep  = v.keep;
        s_axis_tlast  = v.last;
        s_axis_tvalid = 1'b1;
        t = 0;
        while (!s_axis_tready && t < 1000) begin
            @(negedge aclk);
            t++;
        end
        check("send_accepted", 64'(t < 1000), 64'(1'b1));
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain_and_compare(input string name);
        int t;
        int n;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        repeat (6) @(negedge aclk);
        check({name, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            $display("%s beat %0d: data=%h keep=%h last=%0d", name, i,
                     got_q[i].data, got_q[i].keep, got_q[i].last);
            check({name, "_data"}, 64'(got_q[i].data), 64'(exp_q[i].data));
            check({name, "_keep"}, 64'(got_q[i].keep), 64'(exp_q[i].keep));
            check({name, "_last"}, 64'(got_q[i].last), 64'(exp_q[i].last));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Packet table: inputs and the output beats they must produce.
        cases[0].name = "full";   cases[0].bp = 1'b0; cases[0].n_in = 1; cases[0].n_exp = 5;
        cases[0].ins[0] = '{ramp(0), {SW{1'b1}}, 1'b1};
        for (int b = 0; b < 5; b++) cases[0].exp[b] = mk_beat(8 * b, 1, 8, b == 4);

        cases[1].name = "sparse"; cases[1].bp = 1'b0; cases[1].n_in = 2; cases[1].n_exp = 5;
        cases[1].ins[0] = '{ramp(0),  40'h55_5555_5555, 1'b0};
        cases[1].ins[1] = '{ramp(40), 40'h55_5555_5555, 1'b1};
        for (int b = 0; b < 5; b++) cases[1].exp[b] = mk_beat(16 * b, 2, 8, b == 4);

        cases[2].name = "partial"; cases[2].bp = 1'b0; cases[2].n_in = 1; cases[2].n_exp = 2;
        cases[2].ins[0] = '{ramp(0), 40'h00_0000_1FFF, 1'b1};
        cases[2].exp[0] = mk_beat(0, 1, 8, 1'b0);
        cases[2].exp[1] = mk_beat(8, 1, 5, 1'b1);

        cases[3].name = "empty";  cases[3].bp = 1'b0; cases[3].n_in = 1; cases[3].n_exp = 1;
        cases[3].ins[0] = '{ramp(100), '0, 1'b1};
        cases[3].exp[0] = mk_beat(0, 1, 0, 1'b1);

        cases[4].name = "backpressure"; cases[4].bp = 1'b1; cases[4].n_in = 1; cases[4].n_exp = 5;
        cases[4].ins[0] = '{ramp(0), {SW{1'b1}}, 1'b1};
        for (int b = 0; b < 5; b++) cases[4].exp[b] = mk_beat(8 * b, 1, 8, b == 4);

        // Reset state (asynchronous, visible without a clock edge).
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'(1'b0));
        check("rst_tlast",  64'(m_axis_tlast),  64'(1'b0));
        check("rst_tdata",  64'(m_axis_tdata),  64'(0));
        check("rst_tkeep",  64'(m_axis_tkeep),  64'(0));
`ifdef OUTPUT_PIPE_STATS_EN
        check("rst_beat_count", 64'(m_beat_count), 64'(0));
`endif
        repeat (3) @(posedge aclk);
        #2 areset = 1'b0;
        @(negedge aclk);
        check("rst_s_tready", 64'(s_axis_tready), 64'(1'b1));

        for (int c = 0; c < 5; c++) begin
            bp_mode = cases[c].bp;
            bp_idx  = 0;
            for (int b = 0; b < cases[c].n_exp; b++) exp_q.push_back(cases[c].exp[b]);
            for (int k = 0; k < cases[c].n_in; k++) send(cases[c].ins[k]);
            // Right after the tlast beat is taken, input stays closed until the flush completes.
            @(negedge aclk);
            check({cases[c].name, "_flush_blocks"}, 64'(s_axis_tready), 64'(1'b0));
            drain_and_compare(cases[c].name);
            bp_mode = 1'b0;
            check({cases[c].name, "_ready_after"}, 64'(s_axis_tready), 64'(1'b1));
            check({cases[c].name, "_idle"}, 64'(m_axis_tvalid), 64'(1'b0));
        end

        // Reset in the middle of draining a full packet.
        send('{ramp(0), {SW{1'b1}}, 1'b1});
        begin
            int t;
            t = 0;
            while (got_q.size() < 2 && t < 200) begin
                @(negedge aclk);
                t++;
            end
            check("middrain_two_beats", 64'(got_q.size() >= 2), 64'(1'b1));
        end
        @(posedge aclk);
        #2 areset = 1'b1;
        #1;
        check("middrain_tvalid", 64'(m_axis_tvalid), 64'(1'b0));
        check("middrain_tkeep",  64'(m_axis_tkeep),  64'(0));
        repeat (2) @(posedge aclk);
        #2 areset = 1'b0;
        @(negedge aclk);
        check("postrst_s_tready", 64'(s_axis_tready), 64'(1'b1));
        check("postrst_tvalid",   64'(m_axis_tvalid), 64'(1'b0));
`ifdef OUTPUT_PIPE_STATS_EN
        check("postrst_beat_count", 64'(m_beat_count), 64'(0));
`endif
        got_q.delete();
        exp_q.push_back(mk_beat(0, 1, 8, 1'b0));
        exp_q.push_back(mk_beat(8, 1, 5, 1'b1));
        send('{ramp(0), 40'h00_0000_1FFF, 1'b1});
        drain_and_compare("postrst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
